// File: rtl/spart_pkg.sv
// Shared definitions for the SPART processor-side controllers: FSM states,
// I/O register addresses and the default baud divisor.
package spart_pkg;

    typedef enum logic [2:0] {
        ST_CFG_LO   = 3'd0,
        ST_CFG_HI   = 3'd1,
        ST_IDLE     = 3'd2,
        ST_WRITE    = 3'd3,
        ST_WAIT_TBR = 3'd4
    } state_e;

    localparam logic [1:0]  ADDR_TX         = 2'b00;
    localparam logic [1:0]  ADDR_DBL        = 2'b10;
    localparam logic [1:0]  ADDR_DBH        = 2'b11;
    localparam logic [15:0] DIVISOR_DEFAULT = 16'h0145;

endpackage

// File: rtl/spart_tx_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester that did not win last
// time is granted. Purely combinational, shared with the receive-side controller.
module rr_arb2
    import spart_pkg::*;
(
    input  logic       req0,
    input  logic       req1,
    input  logic       last_grant,
    output logic [1:0] gnt
);

    // One-hot grant; bit 0 = requester 0, bit 1 = requester 1
    always_comb begin
        gnt = 2'b00;
        if (req0 && req1) begin
            if (last_grant) begin
                gnt = 2'b01;
            end else begin
                gnt = 2'b10;
            end
        end else if (req0) begin
            gnt = 2'b01;
        end else if (req1) begin
            gnt = 2'b10;
        end else begin
            gnt = 2'b00;
        end
    end

endmodule

// File: rtl/spart_tx_ctrl.sv
// SPART transmit-side bus controller: programs the baud divisor after reset,
// then writes bytes from two requesters round-robin, one per TX-buffer-empty.
module spart_tx_ctrl
    import spart_pkg::*;
#(
    parameter logic [15:0] DIVISOR = DIVISOR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tbr,
    input  logic        req0,
    input  logic [7:0]  data0,
    output logic        gnt0,
    input  logic        req1,
    input  logic [7:0]  data1,
    output logic        gnt1,
    output logic        iocs,
    output logic        iorw,
    output logic [1:0]  ioaddr,
    output logic [7:0]  databus,
    output logic        ready,
    output logic [15:0] tx_count
);

    state_e      state_q, state_d;
    logic        boot_q, boot_d;
    logic        last_grant_q, last_grant_d;
    logic        iocs_q, iocs_d;
    logic        iorw_q, iorw_d;
    logic [1:0]  ioaddr_q, ioaddr_d;
    logic [7:0]  databus_q, databus_d;
    logic        gnt0_q, gnt0_d;
    logic        gnt1_q, gnt1_d;
    logic        ready_q, ready_d;
    logic [15:0] tx_count_q, tx_count_d;
    logic [1:0]  arb_gnt;

    rr_arb2 u_arb (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_grant_q),
        .gnt        (arb_gnt)
    );

    // Next state, then outputs decoded from the next state so they are registered.
    // boot_q holds CFG_LO for one extra edge: the reset cycle itself keeps the bus idle.
    always_comb begin
        state_d      = state_q;
        boot_d       = 1'b0;
        last_grant_d = last_grant_q;
        databus_d    = databus_q;
        tx_count_d   = tx_count_q;
        iocs_d       = 1'b0;
        iorw_d       = 1'b1;
        ioaddr_d     = ADDR_TX;
        gnt0_d       = 1'b0;
        gnt1_d       = 1'b0;
        ready_d      = 1'b0;

        case (state_q)
            ST_CFG_LO: begin
                if (boot_q) begin
                    state_d = ST_CFG_LO;
                end else begin
                    state_d = ST_CFG_HI;
                end
            end
            ST_CFG_HI: state_d = ST_IDLE;
            ST_IDLE: begin
                if (tbr && (req0 || req1)) begin
                    state_d      = ST_WRITE;
                    last_grant_d = arb_gnt[1];
                    databus_d    = arb_gnt[1] ? data1 : data0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: state_d = ST_WAIT_TBR;
            ST_WAIT_TBR: begin
                if (tbr) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_TBR;
                end
            end
            default: state_d = ST_CFG_LO;
        endcase

        case (state_d)
            ST_CFG_LO: begin
                iocs_d    = 1'b1;
                iorw_d    = 1'b0;
                ioaddr_d  = ADDR_DBL;
                databus_d = DIVISOR[7:0];
            end
            ST_CFG_HI: begin
                iocs_d    = 1'b1;
                iorw_d    = 1'b0;
                ioaddr_d  = ADDR_DBH;
                databus_d = DIVISOR[15:8];
            end
            ST_IDLE:     ready_d = 1'b1;
            ST_WRITE: begin
                iocs_d     = 1'b1;
                iorw_d     = 1'b0;
                ioaddr_d   = ADDR_TX;
                gnt0_d     = ~last_grant_d;
                gnt1_d     = last_grant_d;
                tx_count_d = tx_count_q + 16'd1;
                ready_d    = 1'b1;
            end
            ST_WAIT_TBR: ready_d = 1'b1;
            default:     ready_d = 1'b0;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_CFG_LO;
            boot_q       <= 1'b1;
            last_grant_q <= 1'b1;
            iocs_q       <= 1'b0;
            iorw_q       <= 1'b1;
            ioaddr_q     <= ADDR_TX;
            databus_q    <= 8'h00;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            ready_q      <= 1'b0;
            tx_count_q   <= 16'h0000;
        end else begin
            state_q      <= state_d;
            boot_q       <= boot_d;
            last_grant_q <= last_grant_d;
            iocs_q       <= iocs_d;
            iorw_q       <= iorw_d;
            ioaddr_q     <= ioaddr_d;
            databus_q    <= databus_d;
            gnt0_q       <= gnt0_d;
            gnt1_q       <= gnt1_d;
            ready_q      <= ready_d;
            tx_count_q   <= tx_count_d;
        end
    end

    assign iocs     = iocs_q;
    assign iorw     = iorw_q;
    assign ioaddr   = ioaddr_q;
    assign databus  = databus_q;
    assign gnt0     = gnt0_q;
    assign gnt1     = gnt1_q;
    assign ready    = ready_q;
    assign tx_count = tx_count_q;

endmodule

// File: tb/tb_spart_tx_ctrl.sv
// Directed bench for spart_tx_ctrl with a simple transmitter-buffer model on tbr.
module tb_spart_tx_ctrl;

    logic        clk;
    logic        rst;
    logic        tbr;
    logic        req0, req1;
    logic [7:0]  data0, data1;
    logic        gnt0, gnt1;
    logic        iocs, iorw;
    logic [1:0]  ioaddr;
    logic [7:0]  databus;
    logic        ready;
    logic [15:0] tx_count;

    int checks = 0;
    int errors = 0;

    // transmitter model state
    bit tbr_auto;
    bit wrote_prev;
    int busy_cnt;
    int busy_len;

    int rise_t, wr_t, n, viol, gcount;
    bit prev_iocs, tbr_before, ok;
    logic [7:0] seq [4];
    logic [3:0] gsel;

    spart_tx_ctrl #(.DIVISOR(16'h0145)) dut (
        .clk(clk), .rst(rst), .tbr(tbr),
        .req0(req0), .data0(data0), .gnt0(gnt0),
        .req1(req1), .data1(data1), .gnt1(gnt1),
        .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr), .databus(databus),
        .ready(ready), .tx_count(tx_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance one clock, sample 1 time unit after the edge, update tbr model
    task automatic tick();
        @(posedge clk);
        #1;
        if (tbr_auto) begin
            if (wrote_prev) begin
                tbr = 1'b0;
                busy_cnt = busy_len;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) tbr = 1'b1;
            end
        end
        wrote_prev = (iocs === 1'b1) && (ioaddr === 2'b00);
    endtask

    task automatic wait_write(input int bound, output bit found);
        found = 1'b0;
        for (int i = 0; i < bound && !found; i++) begin
            tick();
            if (iocs === 1'b1 && ioaddr === 2'b00) found = 1'b1;
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (tbr !== 1'b1 && k < 50) begin
            tick();
            k++;
        end
        tick();
        tick();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_iocs"},  32'(iocs), 32'h0);
        chk({tag, "_iorw"},  32'(iorw), 32'h1);
        chk({tag, "_addr"},  32'(ioaddr), 32'h0);
        chk({tag, "_data"},  32'(databus), 32'h00);
        chk({tag, "_gnt"},   32'({gnt1, gnt0}), 32'h0);
        chk({tag, "_ready"}, 32'(ready), 32'h0);
        chk({tag, "_cnt"},   32'(tx_count), 32'h0);
    endtask

    task automatic chk_cfg_sequence(input string tag);
        tick();
        chk({tag, "_c1_bus"}, 32'({iocs, iorw, ioaddr, databus}), {20'h0, 1'b1, 1'b0, 2'b10, 8'h45});
        tick();
        chk({tag, "_c2_bus"}, 32'({iocs, iorw, ioaddr, databus}), {20'h0, 1'b1, 1'b0, 2'b11, 8'h01});
        tick();
        chk({tag, "_c3_ready"}, 32'({ready, iocs, iorw}), 32'b101);
    endtask

    initial begin
        rst = 1'b1; tbr = 1'b1; req0 = 1'b0; req1 = 1'b0;
        data0 = 8'h00; data1 = 8'h00;
        tbr_auto = 1'b1; wrote_prev = 1'b0; busy_cnt = 0; busy_len = 3;

        // reset values and divisor programming
        tick(); tick();
        chk_reset_vals("rst");
        rst = 1'b0;
        chk_cfg_sequence("boot");

        // single request from requester 0
        req0 = 1'b1; data0 = 8'hA5;
        tick();
        chk("t2_write", 32'({gnt0, gnt1, iocs, iorw, ioaddr, databus}), {18'h0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 8'hA5});
        chk("t2_count", 32'(tx_count), 32'h1);
        data0 = 8'h5A;
        rise_t = -1; wr_t = -1;
        for (int i = 0; i < 30 && wr_t < 0; i++) begin
            tbr_before = tbr;
            tick();
            if (!tbr_before && tbr && rise_t < 0) rise_t = i;
            if (iocs === 1'b1 && ioaddr === 2'b00) wr_t = i;
        end
        chk("t2_tbr_rose", 32'(rise_t >= 0), 32'h1);
        chk("t2_latency", 32'(wr_t - rise_t), 32'h2);
        chk("t2_second", 32'({gnt0, databus, tx_count}), {7'h0, 1'b1, 8'h5A, 16'h0002});
        req0 = 1'b0;
        wait_idle();

        // both requesters held: round-robin, last winner was requester 0
        req0 = 1'b1; data0 = 8'h11; req1 = 1'b1; data1 = 8'h22;
        n = 0; viol = 0; gcount = 0; prev_iocs = 1'b0; gsel = 4'h0;
        for (int i = 0; i < 200 && n < 4; i++) begin
            tick();
            if (iocs && prev_iocs) viol++;
            prev_iocs = iocs;
            if (gnt0 || gnt1) gcount++;
            if (iocs === 1'b1 && ioaddr === 2'b00) begin
                seq[n] = databus;
                gsel[3 - n] = gnt1;
                n++;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        chk("rr_writes", 32'(n), 32'h4);
        chk("rr_order", {seq[0], seq[1], seq[2], seq[3]}, 32'h22112211);
        chk("rr_gsel", 32'(gsel), 32'hA);
        chk("rr_iocs_b2b", 32'(viol), 32'h0);
        chk("rr_gnt_cycles", 32'(gcount), 32'h4);
        tick();
        chk("rr_gnt_drop", 32'({gnt0, gnt1, iocs}), 32'h0);
        chk("rr_count", 32'(tx_count), 32'h6);
        wait_idle();

        // transmitter busy in IDLE blocks granting
        tbr_auto = 1'b0; tbr = 1'b0;
        req1 = 1'b1; data1 = 8'hC3;
        n = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (iocs || gnt1) n++;
        end
        chk("busy_blocked", 32'(n), 32'h0);
        tbr = 1'b1;
        tbr_auto = 1'b1;
        tick();
        chk("busy_release", 32'({gnt1, iocs, ioaddr, databus}), {20'h0, 1'b1, 1'b1, 2'b00, 8'hC3});
        chk("busy_count", 32'(tx_count), 32'h7);
        req1 = 1'b0;
        wait_idle();

        // tx_count wrap
        force dut.tx_count_q = 16'hFFFE;
        #1;
        release dut.tx_count_q;
        req0 = 1'b1; data0 = 8'h77;
        wait_write(40, ok);
        chk("wrap_w1_seen", 32'(ok), 32'h1);
        chk("wrap_ffff", 32'(tx_count), 32'hFFFF);
        wait_write(40, ok);
        chk("wrap_w2_seen", 32'(ok), 32'h1);
        chk("wrap_zero", 32'(tx_count), 32'h0);
        req0 = 1'b0;
        wait_idle();

        // reset during WAIT_TBR with both requests pending
        busy_len = 5;
        req0 = 1'b1; data0 = 8'h11; req1 = 1'b1; data1 = 8'h22;
        wait_write(40, ok);
        chk("mid_w_seen", 32'(ok), 32'h1);
        tick();
        chk("mid_in_wait", 32'({iocs, ready}), 32'b01);
        rst = 1'b1;
        #1;
        chk_reset_vals("midrst");
        tbr_auto = 1'b0; tbr = 1'b1; busy_cnt = 0;
        tick();
        rst = 1'b0;
        tbr_auto = 1'b1;
        chk_cfg_sequence("rerun");
        tick();
        chk("rerun_grant", 32'({gnt0, gnt1, iocs, ioaddr, databus}), {19'h0, 1'b1, 1'b0, 1'b1, 2'b00, 8'h11});
        chk("rerun_count", 32'(tx_count), 32'h1);
        req0 = 1'b0; req1 = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
